holy_axi_read_arbiter: RTL

Parametrised read-only AXI line-fill engine that lets `NUM_REQ` cache requestors (instruction cache, data cache, prefetcher) share one AXI read master port. It arbitrates round-robin, issues one `BEATS`-long burst per granted request and steers the returned beats to the owning requestor. It sits between the per-cache fill logic and the top-level AXI interconnect.

---
 rtl/holy_axi_read_arbiter_if.sv | 52 +++++
 rtl/holy_axi_read_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/holy_axi_read_arbiter_if.sv
// rtl/holy_axi_read_arbiter_if.sv - requestor and AXI read-channel bundle for holy_axi_read_arbiter
// master: the arbiter side; slave: the requestors plus AXI slave side.
interface holy_axi_read_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BEATS      = 8,
    parameter int ID_WIDTH   = 4
);
    localparam int BEAT_W = $clog2(BEATS);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic [BEAT_W-1:0]             rsp_beat;
    logic                          rsp_last;
    logic                          rsp_err;

    logic [ID_WIDTH-1:0]           axi_arid;
    logic [ADDR_WIDTH-1:0]         axi_araddr;
    logic [7:0]                    axi_arlen;
    logic [2:0]                    axi_arsize;
    logic [1:0]                    axi_arburst;
    logic                          axi_arvalid;
    logic                          axi_arready;
    logic [ID_WIDTH-1:0]           axi_rid;
    logic [DATA_WIDTH-1:0]         axi_rdata;
    logic [1:0]                    axi_rresp;
    logic                          axi_rlast;
    logic                          axi_rvalid;
    logic                          axi_rready;

    modport master (
        input  req_valid, req_addr,
        output req_ready, rsp_valid, rsp_data, rsp_beat, rsp_last, rsp_err,
        output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid,
        input  axi_arready,
        input  axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
        output axi_rready
    );

    modport slave (
        output req_valid, req_addr,
        input  req_ready, rsp_valid, rsp_data, rsp_beat, rsp_last, rsp_err,
        input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid,
        output axi_arready,
        output axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
        input  axi_rready
    );
endinterface

// File: rtl/holy_axi_read_arbiter.sv
// rtl/holy_axi_read_arbiter.sv - round-robin AXI read line-fill arbiter for NUM_REQ cache requestors
// Define HOLY_WRAP_BURST_EN for critical-word-first WRAP bursts; default is line-aligned INCR.
module holy_axi_read_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BEATS      = 8,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    holy_axi_read_arbiter_if.master bus
);
    localparam int BEAT_W = $clog2(BEATS);
    localparam int OFF_W  = $clog2(DATA_WIDTH / 8);
    localparam int LINE_W = OFF_W + BEAT_W;
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef HOLY_WRAP_BURST_EN
    localparam int         ALIGN_W = OFF_W;
    localparam logic [1:0] BURST   = 2'b10;
`else
    localparam int         ALIGN_W = LINE_W;
    localparam logic [1:0] BURST   = 2'b01;
`endif
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ~((ADDR_WIDTH'(1) << ALIGN_W) - ADDR_WIDTH'(1));

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                state_q, state_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [PTR_W-1:0]      gnt_q, gnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [BEAT_W-1:0]     cnt_q, cnt_d;
    logic                  drain_q, drain_d;

    logic [NUM_REQ-1:0]    req_rot;
    logic                  found;
    logic [PTR_W-1:0]      sel;
    logic [PTR_W:0]        sum;
    logic [PTR_W:0]        ptr_nxt;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [NUM_REQ-1:0]    sel_oh;
    logic [NUM_REQ-1:0]    gnt_oh;
    logic [NUM_REQ-1:0]    req_ready_c;
    logic [BEAT_W-1:0]     beat_start;
    logic                  early_last;
    logic                  overrun;

    // Rotate so bit 0 is the requestor at ptr; the lowest set offset wins.
    always_comb begin
        req_rot = NUM_REQ'({bus.req_valid, bus.req_valid} >> ptr_q);
        found   = 1'b0;
        sel     = '0;
        sum     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, ptr_q} + (PTR_W+1)'(k);
                if (sum >= (PTR_W+1)'(NUM_REQ)) begin
                    sum = sum - (PTR_W+1)'(NUM_REQ);
                end
                sel = sum[PTR_W-1:0];
            end
        end
        ptr_nxt = {1'b0, sel} + (PTR_W+1)'(1);
        if (ptr_nxt == (PTR_W+1)'(NUM_REQ)) begin
            ptr_nxt = '0;
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_oh   = '0;
        gnt_oh   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == PTR_W'(i)) begin
                sel_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_oh[i] = 1'b1;
            end
            gnt_oh[i] = (gnt_q == PTR_W'(i));
        end
    end

`ifdef HOLY_WRAP_BURST_EN
    assign beat_start = addr_q[LINE_W-1:OFF_W];
`else
    assign beat_start = '0;
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        addr_d      = addr_q;
        beat_d      = beat_q;
        cnt_d       = cnt_q;
        drain_d     = drain_q;
        early_last  = 1'b0;
        overrun     = 1'b0;
        req_ready_c = '0;
        bus.rsp_valid   = '0;
        bus.rsp_data    = '0;
        bus.rsp_beat    = '0;
        bus.rsp_last    = 1'b0;
        bus.rsp_err     = 1'b0;
        bus.axi_arvalid = 1'b0;
        bus.axi_arid    = '0;
        bus.axi_araddr  = '0;
        bus.axi_arlen   = '0;
        bus.axi_arsize  = '0;
        bus.axi_arburst = '0;
        bus.axi_rready  = drain_q;

        // Stray beats after an overrun are swallowed until the slave sends rlast.
        if (state_q != DATA && drain_q && bus.axi_rvalid && bus.axi_rlast) begin
            drain_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready_c = sel_oh;
                    gnt_d       = sel;
                    addr_d      = sel_addr & ALIGN_MASK;
                    ptr_d       = ptr_nxt[PTR_W-1:0];
                    state_d     = ADDR;
                end
            end
            ADDR: begin
                bus.axi_arvalid = 1'b1;
                bus.axi_arid    = ID_WIDTH'(gnt_q);
                bus.axi_araddr  = addr_q;
                bus.axi_arlen   = 8'(BEATS - 1);
                bus.axi_arsize  = 3'(OFF_W);
                bus.axi_arburst = BURST;
                if (bus.axi_arready) begin
                    beat_d  = beat_start;
                    cnt_d   = '0;
                    drain_d = 1'b0;
                    state_d = DATA;
                end
            end
            DATA: begin
                bus.axi_rready = 1'b1;
                if (bus.axi_rvalid) begin
                    early_last    = bus.axi_rlast && (cnt_q != BEAT_W'(BEATS - 1));
                    overrun       = !bus.axi_rlast && (cnt_q == BEAT_W'(BEATS - 1));
                    bus.rsp_valid = gnt_oh;
                    bus.rsp_data  = bus.axi_rdata;
                    bus.rsp_beat  = beat_q;
                    bus.rsp_last  = bus.axi_rlast || overrun;
                    bus.rsp_err   = (bus.axi_rresp != 2'b00) ||
                                    (bus.axi_rid != ID_WIDTH'(gnt_q)) ||
                                    early_last || overrun;
                    beat_d = beat_q + BEAT_W'(1);
                    cnt_d  = cnt_q + BEAT_W'(1);
                    if (bus.axi_rlast || overrun) begin
                        drain_d = overrun;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready = req_ready_c & {NUM_REQ{rst_n}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            addr_q  <= '0;
            beat_q  <= '0;
            cnt_q   <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
        end
    end
endmodule
